yarvi_mem_arb: RTL and testbench

Two-port arbiter that shares the single `yarvi_me` memory port between instruction fetch and the execute stage's load/store requests. It sits between `yarvi_fe`/`yarvi_ex` and `yarvi_me`:

- It forwards one request per cycle downstream.
- It records the source of every read in an in-order FIFO and routes each read response back to its requester.
- It guarantees fetch forward progress under sustained data traffic.

---
 rtl/yarvi_mem_arb_pkg.sv | 17 +
 rtl/yarvi_srcfifo.sv | 52 +++++
 rtl/yarvi_mem_arb.sv | 164 ++++++++++++++++
 tb/tb_yarvi_mem_arb.sv | 405 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/yarvi_mem_arb_pkg.sv
// Shared widths, source ids and arbiter state encoding for the memory arbiter.
package yarvi_mem_arb_pkg;

    localparam int unsigned VMSB = 31;
    localparam int unsigned XMSB = 31;

    // Source id recorded per outstanding read.
    localparam logic SRC_FE = 1'b0;
    localparam logic SRC_EX = 1'b1;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StHoldFe = 2'd1,
        StHoldEx = 2'd2
    } arb_state_t;

endpackage

// File: rtl/yarvi_srcfifo.sv
// In-order DEPTH x 1-bit FIFO holding the source id of every outstanding read.
module yarvi_srcfifo #(
    parameter int unsigned DEPTH = 4
) (
    input  logic clock,
    input  logic reset,
    input  logic push,
    input  logic din,
    input  logic pop,
    output logic head,
    output logic full,
    output logic empty
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [DEPTH-1:0] mem;
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    count;
    logic             do_push;
    logic             do_pop;

    // Push while full is only legal alongside a pop; pop on empty is ignored.
    always_comb begin
        full    = (count == CW'(DEPTH));
        empty   = (count == '0);
        do_push = push & (~full | pop);
        do_pop  = pop & ~empty;
        head    = mem[rd_ptr];
    end

    // Pointer, count and storage update.
    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

endmodule

// File: rtl/yarvi_mem_arb.sv
// Shares the single memory port between fetch and execute, routing read
// responses back in order and forcing a fetch grant after sustained ex traffic.
module yarvi_mem_arb
    import yarvi_mem_arb_pkg::*;
#(
    parameter int unsigned DEPTH        = 4,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic            clock,
    input  logic            reset,

    input  logic            fe_valid,
    input  logic [VMSB:0]   fe_address,
    input  logic [4:0]      fe_readtag,
    output logic            fe_ready,
    output logic            fe_readdatavalid,
    output logic [4:0]      fe_readdatatag,
    output logic [XMSB:0]   fe_readdata,

    input  logic            ex_valid,
    input  logic            ex_writeenable,
    input  logic [VMSB:0]   ex_address,
    input  logic [XMSB:0]   ex_writedata,
    input  logic [1:0]      ex_sizelg2,
    input  logic [4:0]      ex_readtag,
    input  logic            ex_readsignextend,
    output logic            ex_ready,
    output logic            ex_readdatavalid,
    output logic [4:0]      ex_readdatatag,
    output logic [XMSB:0]   ex_readdata,

    output logic            mem_valid,
    output logic            mem_writeenable,
    output logic [VMSB:0]   mem_address,
    output logic [XMSB:0]   mem_writedata,
    output logic [1:0]      mem_sizelg2,
    output logic [4:0]      mem_readtag,
    output logic            mem_readsignextend,
    input  logic            me_ready,
    input  logic            me_readdatavalid,
    input  logic [4:0]      me_readdatatag,
    input  logic [XMSB:0]   me_readdata
);

    localparam int unsigned SW = $clog2(STARVE_LIMIT + 1);

    arb_state_t    state;
    logic [SW-1:0] starve_cnt;

    logic fifo_full;
    logic fifo_empty;
    logic fifo_head;
    logic fifo_push;
    logic fifo_pop;
    logic room;
    logic fe_elig;
    logic ex_elig;
    logic grant_fe;
    logic grant_ex;

    // A pop in the same cycle frees a slot, so a read may enter a full FIFO then.
    always_comb begin
        fifo_pop = me_readdatavalid & ~fifo_empty & ~reset;
        room     = ~fifo_full | fifo_pop;
        fe_elig  = fe_valid & room;
        ex_elig  = ex_valid & (ex_writeenable | room);
    end

    // Grant selection: held owner keeps the port, otherwise ex unless fe is starved.
    always_comb begin
        grant_fe = 1'b0;
        grant_ex = 1'b0;
        case (state)
            StHoldFe: grant_fe = fe_elig;
            StHoldEx: grant_ex = ex_elig;
            default: begin
                if (ex_elig && fe_elig) begin
                    if (starve_cnt == SW'(STARVE_LIMIT)) grant_fe = 1'b1;
                    else                                 grant_ex = 1'b1;
                end else if (ex_elig) begin
                    grant_ex = 1'b1;
                end else if (fe_elig) begin
                    grant_fe = 1'b1;
                end
            end
        endcase
        if (reset) begin
            grant_fe = 1'b0;
            grant_ex = 1'b0;
        end
    end

    // Downstream request mux and acceptance handshake.
    always_comb begin
        mem_valid = grant_fe | grant_ex;
        if (grant_fe) begin
            mem_writeenable    = 1'b0;
            mem_address        = fe_address;
            mem_writedata      = '0;
            mem_sizelg2        = 2'd2;
            mem_readtag        = fe_readtag;
            mem_readsignextend = 1'b0;
        end else begin
            mem_writeenable    = ex_writeenable;
            mem_address        = ex_address;
            mem_writedata      = ex_writedata;
            mem_sizelg2        = ex_sizelg2;
            mem_readtag        = ex_readtag;
            mem_readsignextend = ex_readsignextend;
        end
        fe_ready  = grant_fe & me_ready;
        ex_ready  = grant_ex & me_ready;
        fifo_push = fe_ready | (ex_ready & ~ex_writeenable);
    end

    // Response demux steered by the FIFO head; tag and data pass straight through.
    always_comb begin
        fe_readdatavalid = fifo_pop & (fifo_head == SRC_FE);
        ex_readdatavalid = fifo_pop & (fifo_head == SRC_EX);
        fe_readdatatag   = me_readdatatag;
        ex_readdatatag   = me_readdatatag;
        fe_readdata      = me_readdata;
        ex_readdata      = me_readdata;
    end

    // Grant-hold FSM and fetch starvation counter.
    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= StIdle;
            starve_cnt <= '0;
        end else begin
            if (grant_fe && !me_ready)      state <= StHoldFe;
            else if (grant_ex && !me_ready) state <= StHoldEx;
            else                            state <= StIdle;

            if (fe_ready || !fe_valid) begin
                starve_cnt <= '0;
            end else if (ex_ready && starve_cnt != SW'(STARVE_LIMIT)) begin
                starve_cnt <= starve_cnt + SW'(1);
            end
        end
    end

    yarvi_srcfifo #(
        .DEPTH (DEPTH)
    ) u_srcfifo (
        .clock (clock),
        .reset (reset),
        .push  (fifo_push),
        .din   (grant_ex ? SRC_EX : SRC_FE),
        .pop   (fifo_pop),
        .head  (fifo_head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // A response with nothing outstanding means downstream and arbiter disagree.
    always_ff @(posedge clock) begin
        if (!reset && me_readdatavalid) begin
            assert (!fifo_empty) else $error("yarvi_mem_arb: response with no outstanding read");
        end
    end

endmodule

// File: tb/tb_yarvi_mem_arb.sv
// Directed bench for yarvi_mem_arb: grant order, backpressure hold, FIFO gating,
// response routing and reset flush.
module tb_yarvi_mem_arb;

    logic        clock = 1'b0;
    logic        reset;
    logic        fe_valid;
    logic [31:0] fe_address;
    logic [4:0]  fe_readtag;
    logic        fe_ready;
    logic        fe_readdatavalid;
    logic [4:0]  fe_readdatatag;
    logic [31:0] fe_readdata;
    logic        ex_valid;
    logic        ex_writeenable;
    logic [31:0] ex_address;
    logic [31:0] ex_writedata;
    logic [1:0]  ex_sizelg2;
    logic [4:0]  ex_readtag;
    logic        ex_readsignextend;
    logic        ex_ready;
    logic        ex_readdatavalid;
    logic [4:0]  ex_readdatatag;
    logic [31:0] ex_readdata;
    logic        mem_valid;
    logic        mem_writeenable;
    logic [31:0] mem_address;
    logic [31:0] mem_writedata;
    logic [1:0]  mem_sizelg2;
    logic [4:0]  mem_readtag;
    logic        mem_readsignextend;
    logic        me_ready;
    logic        me_readdatavalid;
    logic [4:0]  me_readdatatag;
    logic [31:0] me_readdata;

    int vectors = 0;
    int miscompares = 0;

    always #5 clock = ~clock;

    yarvi_mem_arb #(
        .DEPTH        (4),
        .STARVE_LIMIT (4)
    ) dut (
        .clock              (clock),
        .reset              (reset),
        .fe_valid           (fe_valid),
        .fe_address         (fe_address),
        .fe_readtag         (fe_readtag),
        .fe_ready           (fe_ready),
        .fe_readdatavalid   (fe_readdatavalid),
        .fe_readdatatag     (fe_readdatatag),
        .fe_readdata        (fe_readdata),
        .ex_valid           (ex_valid),
        .ex_writeenable     (ex_writeenable),
        .ex_address         (ex_address),
        .ex_writedata       (ex_writedata),
        .ex_sizelg2         (ex_sizelg2),
        .ex_readtag         (ex_readtag),
        .ex_readsignextend  (ex_readsignextend),
        .ex_ready           (ex_ready),
        .ex_readdatavalid   (ex_readdatavalid),
        .ex_readdatatag     (ex_readdatatag),
        .ex_readdata        (ex_readdata),
        .mem_valid          (mem_valid),
        .mem_writeenable    (mem_writeenable),
        .mem_address        (mem_address),
        .mem_writedata      (mem_writedata),
        .mem_sizelg2        (mem_sizelg2),
        .mem_readtag        (mem_readtag),
        .mem_readsignextend (mem_readsignextend),
        .me_ready           (me_ready),
        .me_readdatavalid   (me_readdatavalid),
        .me_readdatatag     (me_readdatatag),
        .me_readdata        (me_readdata)
    );

    task automatic idle_inputs();
        fe_valid          = 1'b0;
        fe_address        = '0;
        fe_readtag        = '0;
        ex_valid          = 1'b0;
        ex_writeenable    = 1'b0;
        ex_address        = '0;
        ex_writedata      = '0;
        ex_sizelg2        = 2'd2;
        ex_readtag        = '0;
        ex_readsignextend = 1'b0;
        me_ready          = 1'b1;
        me_readdatavalid  = 1'b0;
        me_readdatatag    = '0;
        me_readdata       = '0;
    endtask

    // Inputs change on the falling edge; outputs are sampled 1 ns later.
    task automatic next_cycle();
        @(negedge clock);
    endtask

    task automatic test_reset();
        idle_inputs();
        reset            = 1'b1;
        fe_valid         = 1'b1;
        ex_valid         = 1'b1;
        me_readdatavalid = 1'b1;
        for (int i = 0; i < 2; i++) begin
            next_cycle();
            #1;
            vectors++;
            if ({mem_valid, fe_ready, ex_ready, fe_readdatavalid, ex_readdatavalid} !== 5'b0) begin
                miscompares++;
                $display("FAIL reset_outputs[%0d] got %b want 00000", i,
                         {mem_valid, fe_ready, ex_ready, fe_readdatavalid, ex_readdatavalid});
            end
        end
        next_cycle();
        idle_inputs();
        reset = 1'b0;
        #1;
        vectors++;
        if (dut.starve_cnt !== 3'd0 || mem_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_state got starve=%0d mem_valid=%b want 0 0",
                     dut.starve_cnt, mem_valid);
        end
    endtask

    task automatic test_basic_fetch();
        for (int i = 0; i < 4; i++) begin
            next_cycle();
            idle_inputs();
            fe_valid         = (i < 3);
            fe_address       = 32'(4 * i);
            fe_readtag       = 5'(i);
            me_readdatavalid = (i > 0);
            me_readdatatag   = 5'(i - 1);
            me_readdata      = 32'hA000_0000 + 32'(i);
            #1;
            if (i < 3) begin
                vectors++;
                if (fe_ready !== 1'b1 || mem_address !== 32'(4 * i) || mem_writeenable !== 1'b0 ||
                    mem_sizelg2 !== 2'd2 || mem_readtag !== 5'(i)) begin
                    miscompares++;
                    $display("FAIL basic_req[%0d] got rdy=%b addr=%h we=%b sz=%0d tag=%0d want 1 %h 0 2 %0d",
                             i, fe_ready, mem_address, mem_writeenable, mem_sizelg2, mem_readtag,
                             4 * i, i);
                end
            end
            if (i > 0) begin
                vectors++;
                if (fe_readdatavalid !== 1'b1 || fe_readdatatag !== 5'(i - 1) ||
                    fe_readdata !== 32'hA000_0000 + 32'(i)) begin
                    miscompares++;
                    $display("FAIL basic_resp[%0d] got v=%b tag=%0d data=%h want 1 %0d %h", i,
                             fe_readdatavalid, fe_readdatatag, fe_readdata, i - 1,
                             32'hA000_0000 + 32'(i));
                end
            end
            vectors++;
            if (ex_readdatavalid !== 1'b0) begin
                miscompares++;
                $display("FAIL basic_ex_rdv[%0d] got %b want 0", i, ex_readdatavalid);
            end
        end
    endtask

    task automatic test_starvation();
        logic exp_fe;
        for (int i = 0; i < 11; i++) begin
            next_cycle();
            idle_inputs();
            fe_valid       = (i < 10);
            fe_address     = 32'h40;
            fe_readtag     = 5'd3;
            ex_valid       = (i < 10);
            ex_writeenable = 1'b1;
            ex_address     = 32'h80;
            ex_writedata   = 32'hDEAD_BEEF;
            ex_sizelg2     = 2'd0;
            // Answer each fe read the cycle after it is granted.
            me_readdatavalid = (i == 5) || (i == 10);
            me_readdatatag   = 5'd3;
            me_readdata      = 32'h1234_5678;
            #1;
            if (i < 10) begin
                exp_fe = (i % 5 == 4);
                vectors++;
                if (fe_ready !== exp_fe || ex_ready !== !exp_fe || mem_writeenable !== !exp_fe ||
                    dut.starve_cnt !== 3'(i % 5)) begin
                    miscompares++;
                    $display("FAIL starve_grant[%0d] got fe=%b ex=%b we=%b cnt=%0d want %b %b %b %0d",
                             i, fe_ready, ex_ready, mem_writeenable, dut.starve_cnt, exp_fe,
                             !exp_fe, !exp_fe, i % 5);
                end
            end
            if (i == 5 || i == 10) begin
                vectors++;
                if (fe_readdatavalid !== 1'b1 || ex_readdatavalid !== 1'b0) begin
                    miscompares++;
                    $display("FAIL starve_resp[%0d] got fe=%b ex=%b want 1 0", i,
                             fe_readdatavalid, ex_readdatavalid);
                end
            end
        end
    endtask

    task automatic test_backpressure();
        for (int i = 0; i < 7; i++) begin
            next_cycle();
            idle_inputs();
            ex_valid          = (i < 4);
            ex_address        = 32'h100;
            ex_readtag        = 5'd7;
            ex_sizelg2        = 2'd1;
            ex_readsignextend = 1'b1;
            fe_valid          = (i >= 1 && i <= 4);
            fe_address        = 32'h200;
            fe_readtag        = 5'd9;
            me_ready          = (i >= 3);
            me_readdatavalid  = (i >= 5);
            me_readdatatag    = (i == 5) ? 5'd7 : 5'd9;
            me_readdata       = (i == 5) ? 32'h55 : 32'h66;
            #1;
            vectors++;
            if (i < 3) begin
                if (mem_valid !== 1'b1 || mem_address !== 32'h100 || ex_ready !== 1'b0 ||
                    fe_ready !== 1'b0 || mem_sizelg2 !== 2'd1 || mem_readsignextend !== 1'b1) begin
                    miscompares++;
                    $display("FAIL bp_stall[%0d] got v=%b addr=%h ex=%b fe=%b sz=%0d se=%b want 1 100 0 0 1 1",
                             i, mem_valid, mem_address, ex_ready, fe_ready, mem_sizelg2,
                             mem_readsignextend);
                end
            end else if (i == 3) begin
                if (ex_ready !== 1'b1 || fe_ready !== 1'b0 || mem_address !== 32'h100) begin
                    miscompares++;
                    $display("FAIL bp_release got ex=%b fe=%b addr=%h want 1 0 100",
                             ex_ready, fe_ready, mem_address);
                end
            end else if (i == 4) begin
                if (fe_ready !== 1'b1 || mem_address !== 32'h200 || mem_sizelg2 !== 2'd2 ||
                    mem_readsignextend !== 1'b0) begin
                    miscompares++;
                    $display("FAIL bp_fe_next got fe=%b addr=%h sz=%0d se=%b want 1 200 2 0",
                             fe_ready, mem_address, mem_sizelg2, mem_readsignextend);
                end
            end else if (i == 5) begin
                if (ex_readdatavalid !== 1'b1 || fe_readdatavalid !== 1'b0 ||
                    ex_readdatatag !== 5'd7 || ex_readdata !== 32'h55) begin
                    miscompares++;
                    $display("FAIL bp_ex_resp got ex=%b fe=%b tag=%0d data=%h want 1 0 7 55",
                             ex_readdatavalid, fe_readdatavalid, ex_readdatatag, ex_readdata);
                end
            end else begin
                if (fe_readdatavalid !== 1'b1 || ex_readdatavalid !== 1'b0 ||
                    fe_readdatatag !== 5'd9 || fe_readdata !== 32'h66) begin
                    miscompares++;
                    $display("FAIL bp_fe_resp got fe=%b ex=%b tag=%0d data=%h want 1 0 9 66",
                             fe_readdatavalid, ex_readdatavalid, fe_readdatatag, fe_readdata);
                end
            end
        end
    endtask

    task automatic test_fifo_full();
        for (int i = 0; i < 12; i++) begin
            next_cycle();
            idle_inputs();
            ex_valid       = (i < 5);
            ex_writeenable = (i == 4);
            ex_address     = (i == 4) ? 32'h400 : 32'h300 + 32'(4 * i);
            ex_readtag     = 5'(10 + i);
            fe_valid       = (i >= 4 && i <= 6);
            fe_address     = 32'h500;
            fe_readtag     = 5'd20;
            me_readdatavalid = (i >= 6 && i <= 10);
            me_readdatatag   = (i == 10) ? 5'd20 : 5'(4 + i);
            me_readdata      = 32'(i);
            #1;
            vectors++;
            if (i < 4) begin
                if (ex_ready !== 1'b1) begin
                    miscompares++;
                    $display("FAIL full_fill[%0d] got ex_ready=%b want 1", i, ex_ready);
                end
            end else if (i == 4) begin
                if (ex_ready !== 1'b1 || fe_ready !== 1'b0 || mem_writeenable !== 1'b1) begin
                    miscompares++;
                    $display("FAIL full_write got ex=%b fe=%b we=%b want 1 0 1",
                             ex_ready, fe_ready, mem_writeenable);
                end
            end else if (i == 5) begin
                if (fe_ready !== 1'b0 || mem_valid !== 1'b0 || dut.starve_cnt !== 3'd1) begin
                    miscompares++;
                    $display("FAIL full_block got fe=%b v=%b cnt=%0d want 0 0 1",
                             fe_ready, mem_valid, dut.starve_cnt);
                end
            end else if (i == 6) begin
                if (fe_ready !== 1'b1 || ex_readdatavalid !== 1'b1 || ex_readdatatag !== 5'd10 ||
                    fe_readdatavalid !== 1'b0) begin
                    miscompares++;
                    $display("FAIL full_pop_push got fe=%b exv=%b tag=%0d fev=%b want 1 1 10 0",
                             fe_ready, ex_readdatavalid, ex_readdatatag, fe_readdatavalid);
                end
            end else if (i < 10) begin
                if (ex_readdatavalid !== 1'b1 || ex_readdatatag !== 5'(4 + i) ||
                    fe_readdatavalid !== 1'b0) begin
                    miscompares++;
                    $display("FAIL full_drain[%0d] got exv=%b tag=%0d fev=%b want 1 %0d 0", i,
                             ex_readdatavalid, ex_readdatatag, fe_readdatavalid, 4 + i);
                end
            end else if (i == 10) begin
                if (fe_readdatavalid !== 1'b1 || fe_readdatatag !== 5'd20 ||
                    ex_readdatavalid !== 1'b0) begin
                    miscompares++;
                    $display("FAIL full_fe_resp got fev=%b tag=%0d exv=%b want 1 20 0",
                             fe_readdatavalid, fe_readdatatag, ex_readdatavalid);
                end
            end else begin
                if (fe_readdatavalid !== 1'b0 || ex_readdatavalid !== 1'b0) begin
                    miscompares++;
                    $display("FAIL full_quiet got fev=%b exv=%b want 0 0",
                             fe_readdatavalid, ex_readdatavalid);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 9; i++) begin
            next_cycle();
            idle_inputs();
            reset      = (i == 2) || (i == 8);
            fe_valid   = (i <= 2);
            fe_address = 32'h600 + 32'(4 * i);
            fe_readtag = 5'(1 + i);
            ex_valid   = (i >= 1 && i <= 7);
            ex_address = 32'h700 + 32'(4 * i);
            ex_readtag = 5'(3 + i);
            // Stray response while reset is high must be swallowed.
            me_readdatavalid = (i == 2);
            me_readdatatag   = 5'd1;
            #1;
            vectors++;
            if (i == 0) begin
                if (fe_ready !== 1'b1) begin
                    miscompares++;
                    $display("FAIL rst_pre_fe got fe_ready=%b want 1", fe_ready);
                end
            end else if (i == 1) begin
                if (ex_ready !== 1'b1 || fe_ready !== 1'b0) begin
                    miscompares++;
                    $display("FAIL rst_pre_ex got ex=%b fe=%b want 1 0", ex_ready, fe_ready);
                end
            end else if (i == 2 || i == 8) begin
                if ({mem_valid, fe_ready, ex_ready, fe_readdatavalid, ex_readdatavalid} !== 5'b0) begin
                    miscompares++;
                    $display("FAIL rst_mid_outputs[%0d] got %b want 00000", i,
                             {mem_valid, fe_ready, ex_ready, fe_readdatavalid, ex_readdatavalid});
                end
            end else if (i == 3) begin
                if (ex_ready !== 1'b1 || dut.starve_cnt !== 3'd0) begin
                    miscompares++;
                    $display("FAIL rst_post got ex=%b cnt=%0d want 1 0", ex_ready, dut.starve_cnt);
                end
            end else if (i < 7) begin
                // Only a flushed FIFO has room for four new reads.
                if (ex_ready !== 1'b1) begin
                    miscompares++;
                    $display("FAIL rst_flush_fill[%0d] got ex_ready=%b want 1", i, ex_ready);
                end
            end else begin
                if (ex_ready !== 1'b0 || mem_valid !== 1'b0) begin
                    miscompares++;
                    $display("FAIL rst_flush_full got ex=%b v=%b want 0 0", ex_ready, mem_valid);
                end
            end
        end
        next_cycle();
        idle_inputs();
        reset = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        idle_inputs();
        reset = 1'b1;
        next_cycle();
        test_reset();
        test_basic_fetch();
        test_starvation();
        test_backpressure();
        test_fifo_full();
        test_reset_mid();
        next_cycle();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
